// File: rtl/scope_capture_pkg.sv
// Shared types and register map for the scope capture block.
package scope_capture_pkg;

  localparam int CAP_DW = 12;
  localparam int CAP_AW = 10;

  localparam logic [7:0] CAP_START = 8'h40;
  localparam logic [7:0] CAP_ABORT = 8'h41;
  localparam logic [7:0] CAP_LEN   = 8'h42;
  localparam logic [7:0] CAP_TRIG  = 8'h43;
  localparam logic [7:0] CAP_LEVEL = 8'h44;

  typedef enum logic [1:0] {
    TRIG_IMM  = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_FALL = 2'd2,
    TRIG_IMM3 = 2'd3
  } trig_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port sample buffer, one clock, registered read (1-cycle latency).
module scope_ram #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Captures triggered sample bursts into a buffer and streams them out as byte pairs (hi, lo).
// Sustains one byte per cycle while tx_ready stays high; tx_data holds while stalled.
module scope_capture
  import scope_capture_pkg::*;
#(
  parameter int DW = CAP_DW,
  parameter int AW = CAP_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_wr,
  input  logic [7:0]    m_addr,
  input  logic [15:0]   m_wrdata,
  input  logic [DW-1:0] s_data,
  input  logic          s_flag,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          cap_busy,
  output logic          cap_done
);

  localparam int            DEPTH     = 2**AW;
  localparam logic [AW:0]   LEN_MAX   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] LEVEL_RST = {1'b1, {(DW-1){1'b0}}};

  cap_state_t    state;
  trig_mode_t    mode_q;
  logic [AW:0]   cap_len, len_q, wr_ptr, rd_ptr;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_level, level_q, prev, rd_data;
  logic [7:0]    lo_q;
  logic          prev_valid, rd_ok, lo_phase;

  logic          start_req, abort_req, trig, ram_we, tx_take, can_load, need_hi;
  logic [AW:0]   wr_ptr_nxt;

  assign start_req  = m_wr && (m_addr == CAP_START) && m_wrdata[0];
  assign abort_req  = m_wr && (m_addr == CAP_ABORT) && m_wrdata[0];
  assign wr_ptr_nxt = wr_ptr + PTR_ONE;
  assign tx_take    = tx_valid && tx_ready;
  // rd_ok means rd_data already reflects the sample at rd_ptr.
  assign can_load   = rd_ok && (rd_ptr < len_q);
  assign need_hi    = !tx_valid || (tx_take && lo_phase);

  always_comb begin
    trig = 1'b0;
    case (mode_q)
      TRIG_RISE: trig = prev_valid && (prev <  level_q) && (s_data >= level_q);
      TRIG_FALL: trig = prev_valid && (prev >= level_q) && (s_data <  level_q);
      default:   trig = 1'b1;
    endcase
  end

  assign ram_we = s_flag && !abort_req &&
                  (((state == ST_ARMED) && trig) || (state == ST_CAPTURE));

  scope_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cap_len    <= LEN_MAX;
      trig_mode  <= 2'd0;
      trig_level <= LEVEL_RST;
      len_q      <= LEN_MAX;
      mode_q     <= TRIG_IMM;
      level_q    <= LEVEL_RST;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rd_ok      <= 1'b0;
      lo_phase   <= 1'b0;
      lo_q       <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cap_busy   <= 1'b0;
      cap_done   <= 1'b0;
    end else begin
      cap_done <= 1'b0;
      if (m_wr) begin
        case (m_addr)
          CAP_LEN: begin
            if (m_wrdata == 16'd0 || m_wrdata > 16'(DEPTH)) cap_len <= LEN_MAX;
            else cap_len <= m_wrdata[AW:0];
          end
          CAP_TRIG:  trig_mode  <= m_wrdata[1:0];
          CAP_LEVEL: trig_level <= m_wrdata[DW-1:0];
          default: ;
        endcase
      end

      if (abort_req) begin
        state    <= ST_IDLE;
        tx_valid <= 1'b0;
        cap_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start_req) begin
            state      <= ST_ARMED;
            cap_busy   <= 1'b1;
            wr_ptr     <= '0;
            prev_valid <= 1'b0;
            len_q      <= cap_len;
            mode_q     <= trig_mode_t'(trig_mode);
            level_q    <= trig_level;
          end
          ST_ARMED: if (s_flag) begin
            if (trig) begin
              wr_ptr <= PTR_ONE;
              rd_ptr <= '0;
              rd_ok  <= 1'b0;
              state  <= (len_q == PTR_ONE) ? ST_SEND : ST_CAPTURE;
            end else begin
              prev       <= s_data;
              prev_valid <= 1'b1;
            end
          end
          ST_CAPTURE: if (s_flag) begin
            wr_ptr <= wr_ptr_nxt;
            if (wr_ptr_nxt == len_q) begin
              state  <= ST_SEND;
              rd_ptr <= '0;
              rd_ok  <= 1'b0;
            end
          end
          ST_SEND: begin
            rd_ok <= 1'b1;
            if (need_hi) begin
              if (tx_take && rd_ptr == len_q) begin
                state    <= ST_IDLE;
                tx_valid <= 1'b0;
                cap_busy <= 1'b0;
                cap_done <= 1'b1;
              end else if (can_load) begin
                tx_data  <= 8'(rd_data[DW-1:8]);
                lo_q     <= rd_data[7:0];
                tx_valid <= 1'b1;
                lo_phase <= 1'b0;
                rd_ptr   <= rd_ptr + PTR_ONE;
                rd_ok    <= 1'b0;
              end else if (tx_take) begin
                tx_valid <= 1'b0;
              end
            end else if (tx_take) begin
              tx_data  <= lo_q;
              lo_phase <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
